if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage feeding the IF/ID pipeline register. Holds the PC,
//   issues requests to instruction memory over a req/gnt + rvalid handshake,
//   buffers the returned word until the hazard unit lets IF/ID load it, and
//   applies branch/jump redirects from ID, discarding stale in-flight fetches.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value after reset
//   NOP_INSTR  32'h0000_0000  word driven on instr_o when valid_o=0
// PORTS
//   clk            in   1   clock
//   rst            in   1   reset, synchronous, active-high
//   stall_i        in   1   hazard unit holds IF/ID (IF/ID EN = ~stall_i)
//   redirect_i     in   1   taken branch/jump resolved in ID
//   redirect_pc_i  in   32  redirect target
//   imem_req_o     out  1   fetch request to instruction memory
//   imem_addr_o    out  32  fetch address (= pc)
//   imem_gnt_i     in   1   request accepted this cycle
//   imem_rvalid_i  in   1   read data valid
//   imem_rdata_i   in   32  read data
//   pc_plus4_o     out  32  pc + 4, to IF/ID PCplus4 input
//   instr_o        out  32  fetched instruction, to IF/ID instruction input
//   valid_o        out  1   instr_o/pc_plus4_o hold a real instruction
//   fetch_busy_o   out  1   = ~valid_o; hazard unit flushes IF/ID (bubble)
// BEHAVIOUR
//   - Registers: state, pc, instr_buf, discard. Outputs below combinational
//     from these; pc_plus4_o = pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC).
//   - Reset: state=REQ, pc=RESET_PC, instr_buf=NOP_INSTR, discard=0 ->
//     valid_o=0, instr_o=NOP_INSTR, pc_plus4_o=RESET_PC+4, imem_req_o=1.
//   - Redirect target latched as {redirect_pc_i[31:2],2'b00}.
//   - REQ: imem_req_o = ~redirect_i, imem_addr_o=pc.
//       redirect_i -> pc<=target, stay REQ (request withdrawn that cycle).
//       else gnt -> WAIT; else stay REQ, addr held stable.
//   - WAIT: imem_req_o=0. rvalid honoured only in this state.
//       rvalid & (discard | redirect_i) -> drop data, discard<=0,
//         pc<=target if redirect_i, -> REQ.
//       rvalid & clean -> instr_buf<=rdata, -> HOLD.
//       no rvalid & redirect_i -> pc<=target, discard<=1, stay WAIT.
//   - HOLD: valid_o=1 unless redirect_i, instr_o=instr_buf.
//       redirect_i (wins over stall_i) -> pc<=target, valid_o=0, -> REQ.
//       else ~stall_i (IF/ID captures) -> pc<=pc+4, -> REQ.
//       else stay HOLD, outputs stable.
//   - valid_o=0 and instr_o=NOP_INSTR in REQ and WAIT.
//   - Minimum 3 cycles per instruction (REQ, WAIT, HOLD) with 1-cycle memory.
//   - rst has priority over everything, any state; rvalid for a request
//     issued before reset arrives in REQ and is ignored.
//   - Repeated redirects while discard=1 simply overwrite pc.
// TESTING
//   T1 reset, gnt=1, rvalid 1 cycle after gnt, stall=0, mem[a]=a|32'hA000_0000
//      -> addrs 0,4,8 issued; valid_o every 3rd cycle; pc_plus4_o 4,8,C.
//   T2 stall_i=1 for 5 cycles in HOLD -> instr_o, pc_plus4_o constant,
//      imem_req_o=0; release -> next req addr = pc+4 following cycle.
//   T3 redirect_i to 32'h0000_0103 in WAIT, rvalid 2 cycles later with
//      32'hDEADBEEF -> word dropped, valid_o stays 0, next req addr 0x100.
//   T4 redirect_i=1 and stall_i=1 together in HOLD, target 0x200 -> valid_o=0
//      same cycle, REQ with addr 0x200 next cycle.
//   T5 gnt withheld 4 cycles -> imem_req_o=1, addr stable all 4 cycles.
//   T6 rst in WAIT, rvalid next cycle -> ignored, req addr RESET_PC, valid_o=0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory handshake bundle: req/gnt for the address phase,
// rvalid/rdata for the response phase.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake, buffers
// the word until IF/ID takes it, and applies ID redirects, dropping stale fetches.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    if_fetch_stage_if.master        imem_io,
    output logic [31:0]             pc_plus4_o,
    output logic [31:0]             instr_o,
    output logic                    valid_o,
    output logic                    fetch_busy_o
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_buf_q, instr_buf_d;
    logic        discard_q, discard_d;

    logic [31:0] target;
    logic        unused_redirect_lsbs;

    // Targets are word aligned; the low bits of the redirect address are ignored.
    assign target               = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            instr_buf_q <= NOP_INSTR;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
            discard_q   <= discard_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_buf_d = instr_buf_q;
        discard_d   = discard_q;
        imem_io.req = 1'b0;
        valid_o     = 1'b0;
        instr_o     = NOP_INSTR;

        unique case (state_q)
            StReq: begin
                // A redirect withdraws the request so the old PC is never granted.
                imem_io.req = ~redirect_i;
                if (redirect_i) begin
                    pc_d = target;
                end else if (imem_io.gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_io.rvalid) begin
                    if (discard_q || redirect_i) begin
                        discard_d = 1'b0;
                        if (redirect_i) begin
                            pc_d = target;
                        end
                        state_d = StReq;
                    end else begin
                        instr_buf_d = imem_io.rdata;
                        state_d     = StHold;
                    end
                end else if (redirect_i) begin
                    // Fetch still in flight: remember to drop its data when it lands.
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                valid_o = ~redirect_i;
                instr_o = instr_buf_q;
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = StReq;
                end else if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    assign imem_io.addr = pc_q;
    assign pc_plus4_o   = pc_q + 32'd4;
    assign fetch_busy_o = ~valid_o;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stage and a simple memory.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        fetch_busy_o;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_io       (imem),
        .pc_plus4_o    (pc_plus4_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o),
        .fetch_busy_o  (fetch_busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the stage is doing, as plain flags.
    bit          m_init = 0;
    logic [31:0] m_pc;
    bit          m_outstanding;  // request granted, response not yet seen
    bit          m_stale;        // outstanding response belongs to an old PC
    bit          m_have;         // holding a word for IF/ID
    logic [31:0] m_instr;

    // Memory side.
    bit          mem_pending = 0;
    logic [31:0] mem_addr = 32'h0;

    // Outputs sampled in the last cycle.
    logic        s_valid, s_req, s_busy;
    logic [31:0] s_instr, s_pcp4, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic rs, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic g, input logic rv,
                         input logic [31:0] rdat);
        logic [31:0] tgt;
        logic        e_valid, e_req;
        logic [31:0] e_instr;
        rst           = rs;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem.gnt      = g;
        imem.rvalid   = rv;
        imem.rdata    = rdat;
        #1;
        s_valid = valid_o;
        s_req   = imem.req;
        s_busy  = fetch_busy_o;
        s_instr = instr_o;
        s_pcp4  = pc_plus4_o;
        s_addr  = imem.addr;
        tgt     = rpc & 32'hFFFF_FFFC;
        if (m_init) begin
            e_valid = m_have && !rd;
            e_req   = !m_have && !m_outstanding && !rd;
            e_instr = m_have ? m_instr : NOP_INSTR;
            chk("valid_o", {31'd0, s_valid}, {31'd0, e_valid});
            chk("imem_req", {31'd0, s_req}, {31'd0, e_req});
            chk("fetch_busy", {31'd0, s_busy}, {31'd0, !e_valid});
            chk("instr_o", s_instr, e_instr);
            chk("pc_plus4", s_pcp4, m_pc + 32'd4);
            chk("imem_addr", s_addr, m_pc);
            if (e_valid && !st) begin
                chk("captured_word_matches_pc", s_instr, mem_word(m_pc));
            end
        end
        @(posedge clk);
        if (rs) begin
            m_init        = 1;
            m_pc          = RESET_PC;
            m_outstanding = 0;
            m_stale       = 0;
            m_have        = 0;
            m_instr       = NOP_INSTR;
        end else if (m_have) begin
            if (rd) begin
                m_pc   = tgt;
                m_have = 0;
            end else if (!st) begin
                m_pc   = m_pc + 32'd4;
                m_have = 0;
            end
        end else if (m_outstanding) begin
            if (rv) begin
                m_outstanding = 0;
                if (m_stale || rd) begin
                    m_stale = 0;
                    if (rd) m_pc = tgt;
                end else begin
                    m_have  = 1;
                    m_instr = rdat;
                end
            end else if (rd) begin
                m_pc    = tgt;
                m_stale = 1;
            end
        end else begin
            if (rd) m_pc = tgt;
            else if (g) m_outstanding = 1;
        end
        if (rv) mem_pending = 0;
        if (s_req === 1'b1 && g) begin
            mem_pending = 1;
            mem_addr    = s_addr;
        end
        @(negedge clk);
    endtask

    // Cycle with memory answering the pending request when rv_en allows.
    task automatic mcycle(input logic st, input logic rd, input logic [31:0] rpc,
                          input logic g, input logic rv_en);
        cycle(1'b0, st, rd, rpc, g, mem_pending && rv_en, mem_word(mem_addr));
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // T1: back-to-back fetches with 1-cycle memory.
        for (int c = 0; c < 9; c++) begin
            mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (c == 0) begin
                chk("t1_reset_addr", s_addr, RESET_PC);
                chk("t1_reset_req", {31'd0, s_req}, 32'd1);
                chk("t1_reset_pcp4", s_pcp4, RESET_PC + 32'd4);
                chk("t1_reset_instr", s_instr, NOP_INSTR);
            end
            if (c % 3 == 2) begin
                chk("t1_valid", {31'd0, s_valid}, 32'd1);
                chk("t1_pcp4", s_pcp4, 32'd4 * (c / 3 + 1));
            end else begin
                chk("t1_invalid", {31'd0, s_valid}, 32'd0);
            end
            if (c % 3 == 0) chk("t1_addr", s_addr, 32'd4 * (c / 3));
        end

        // T2: stall in HOLD for 5 cycles.
        mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            mcycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("t2_instr", s_instr, 32'hA000_000C);
            chk("t2_pcp4", s_pcp4, 32'h10);
            chk("t2_req", {31'd0, s_req}, 32'd0);
        end
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_next_addr", s_addr, 32'h10);

        // T3: redirect while the fetch is in flight; the late word is dropped.
        mcycle(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("t3_dropped_valid", {31'd0, s_valid}, 32'd0);
        mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_addr", s_addr, 32'h100);
        chk("t3_req", {31'd0, s_req}, 32'd1);
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // T4: redirect beats stall in HOLD.
        mcycle(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        chk("t4_valid", {31'd0, s_valid}, 32'd0);
        chk("t4_busy", {31'd0, s_busy}, 32'd1);

        // T5: grant withheld for 4 cycles.
        for (int c = 0; c < 4; c++) begin
            mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("t5_req", {31'd0, s_req}, 32'd1);
            chk("t5_addr", s_addr, 32'h200);
        end
        mcycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // T6: reset in WAIT; the response arriving afterwards is ignored.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_addr", s_addr, RESET_PC);
        chk("t6_req", {31'd0, s_req}, 32'd1);
        chk("t6_valid", {31'd0, s_valid}, 32'd0);
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_still_invalid", {31'd0, s_valid}, 32'd0);

        // PC+4 wraps at the top of the address space.
        mcycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        mcycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", s_pcp4, 32'h0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic        rs, st, rd, g, rv;
            logic [31:0] rpc;
            rs  = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'd0, rpc[3:0]};
            g   = $urandom_range(0, 1) == 1;
            rv  = mem_pending && ($urandom_range(0, 1) == 1);
            cycle(rs, st, rd, rpc, g, rv, mem_word(mem_addr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
